// File: rtl/gpio_ctrl_pkg.sv
// Shared constants for the GPIO control bank: per-channel config bit layout
// and the serial-chain event encoding used by the bank controller.
package gpio_ctrl_pkg;

    localparam int PAD_CTRL_BITS_DEFAULT = 10;

    localparam int MGMT_EN_BIT = 0;
    localparam int OE_OVR_BIT  = 1;
    localparam int IE_BIT      = 2;
    localparam int OE_BIT      = 3;
    localparam int SCHMITT_BIT = 4;
    localparam int SLEW_BIT    = 5;
    localparam int PD_BIT      = 6;
    localparam int PU_BIT      = 7;
    localparam int DRIVE_LSB   = 8;
    localparam int DRIVE_W     = 2;

    // Resolved serial-chain action for one cycle, in priority order.
    typedef enum logic [1:0] {
        EV_NONE,
        EV_LOAD,
        EV_READBACK,
        EV_SHIFT
    } serial_event_e;

endpackage

// File: rtl/gpio_control_channel.sv
// One GPIO channel: holds the committed pad configuration word and muxes
// management/user sources onto the pad.
module gpio_control_channel
    import gpio_ctrl_pkg::*;
#(
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEFAULT
) (
    input  logic                     serial_clock,
    input  logic                     reset,
    input  logic [PAD_CTRL_BITS-1:0] cfg_default,
    input  logic                     cfg_commit,
    input  logic [PAD_CTRL_BITS-1:0] cfg_new,
    input  logic                     mgmt_gpio_out,
    input  logic                     mgmt_gpio_oeb,
    input  logic                     user_gpio_out,
    input  logic                     user_gpio_oeb,
    input  logic                     pad_gpio_in,
    output logic [PAD_CTRL_BITS-1:0] cfg,
    output logic                     mgmt_gpio_in,
    output logic                     user_gpio_in,
    output logic                     pad_gpio_out,
    output logic                     pad_gpio_outen,
    output logic                     pad_gpio_inen,
    output logic                     pad_gpio_slew_sel,
    output logic                     pad_gpio_schmitt_sel,
    output logic                     pad_gpio_pullup_sel,
    output logic                     pad_gpio_pulldown_sel,
    output logic [DRIVE_W-1:0]       pad_gpio_drive_sel
);

    logic [PAD_CTRL_BITS-1:0] cfg_reg;

    // The power-on word is an input, so reset behaves as an asynchronous load.
    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            cfg_reg <= cfg_default;
        end else if (cfg_commit) begin
            cfg_reg <= cfg_new;
        end
    end

    assign cfg = cfg_reg;

    assign pad_gpio_out   = cfg_reg[MGMT_EN_BIT] ? mgmt_gpio_out : user_gpio_out;
    assign pad_gpio_outen = cfg_reg[OE_OVR_BIT]  ? cfg_reg[OE_BIT]
                          : (cfg_reg[MGMT_EN_BIT] ? ~mgmt_gpio_oeb : ~user_gpio_oeb);

    assign mgmt_gpio_in = pad_gpio_in;
    assign user_gpio_in = pad_gpio_in;

    assign pad_gpio_inen         = cfg_reg[IE_BIT];
    assign pad_gpio_slew_sel     = cfg_reg[SLEW_BIT];
    assign pad_gpio_schmitt_sel  = cfg_reg[SCHMITT_BIT];
    assign pad_gpio_pullup_sel   = cfg_reg[PU_BIT];
    assign pad_gpio_pulldown_sel = cfg_reg[PD_BIT];
    assign pad_gpio_drive_sel    = cfg_reg[DRIVE_LSB +: DRIVE_W];

endmodule

// File: rtl/gpio_control_bank.sv
// GPIO control bank: serial configuration chain with length-checked commit and
// readback, feeding NCH per-channel config registers and pad muxes.
module gpio_control_bank
    import gpio_ctrl_pkg::*;
#(
    parameter int NCH           = 4,
    parameter int PAD_CTRL_BITS = PAD_CTRL_BITS_DEFAULT
) (
    input  logic                         serial_clock,
    input  logic                         reset,
    input  logic [NCH*PAD_CTRL_BITS-1:0] gpio_defaults,
    input  logic                         serial_data_in,
    input  logic                         serial_shift_en,
    input  logic                         serial_load,
    input  logic                         serial_readback,
    output logic                         serial_data_out,
    output logic                         load_done,
    output logic                         load_error,
    input  logic [NCH-1:0]               mgmt_gpio_out,
    input  logic [NCH-1:0]               mgmt_gpio_oeb,
    input  logic [NCH-1:0]               user_gpio_out,
    input  logic [NCH-1:0]               user_gpio_oeb,
    input  logic [NCH-1:0]               pad_gpio_in,
    output logic [NCH-1:0]               mgmt_gpio_in,
    output logic [NCH-1:0]               user_gpio_in,
    output logic [NCH-1:0]               pad_gpio_out,
    output logic [NCH-1:0]               pad_gpio_outen,
    output logic [NCH-1:0]               pad_gpio_inen,
    output logic [NCH-1:0]               pad_gpio_slew_sel,
    output logic [NCH-1:0]               pad_gpio_schmitt_sel,
    output logic [NCH-1:0]               pad_gpio_pullup_sel,
    output logic [NCH-1:0]               pad_gpio_pulldown_sel,
    output logic [2*NCH-1:0]             pad_gpio_drive_sel
);

    localparam int TOTAL = NCH * PAD_CTRL_BITS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TOTAL);

    logic [TOTAL-1:0] sr_reg, sr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             load_q_reg;
    logic             sdo_reg;
    logic             load_done_reg, load_done_next;
    logic             load_error_reg, load_error_next;
    logic             commit;
    logic [TOTAL-1:0] active_cfg;
    serial_event_e    evt;

    // A load edge pre-empts readback, which pre-empts shifting.
    always_comb begin
        evt = EV_NONE;
        if (serial_load && !load_q_reg) begin
            evt = EV_LOAD;
        end else if (serial_readback) begin
            evt = EV_READBACK;
        end else if (serial_shift_en) begin
            evt = EV_SHIFT;
        end
    end

    always_comb begin
        sr_next         = sr_reg;
        cnt_next        = cnt_reg;
        load_done_next  = 1'b0;
        load_error_next = load_error_reg;
        commit          = 1'b0;
        case (evt)
            EV_LOAD: begin
                cnt_next = '0;
                if (cnt_reg == CNT_FULL) begin
                    commit          = 1'b1;
                    load_done_next  = 1'b1;
                    load_error_next = 1'b0;
                end else begin
                    load_error_next = 1'b1;
                end
            end
            EV_READBACK: begin
                sr_next  = active_cfg;
                cnt_next = '0;
            end
            EV_SHIFT: begin
                sr_next = {sr_reg[TOTAL-2:0], serial_data_in};
                if (cnt_reg != CNT_FULL) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge serial_clock or posedge reset) begin
        if (reset) begin
            sr_reg         <= '0;
            cnt_reg        <= '0;
            load_q_reg     <= 1'b0;
            sdo_reg        <= 1'b0;
            load_done_reg  <= 1'b0;
            load_error_reg <= 1'b0;
        end else begin
            sr_reg         <= sr_next;
            cnt_reg        <= cnt_next;
            load_q_reg     <= serial_load;
            sdo_reg        <= sr_reg[TOTAL-1];
            load_done_reg  <= load_done_next;
            load_error_reg <= load_error_next;
        end
    end

    assign serial_data_out = sdo_reg;
    assign load_done       = load_done_reg;
    assign load_error      = load_error_reg;

    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
            gpio_control_channel #(
                .PAD_CTRL_BITS(PAD_CTRL_BITS)
            ) u_chan (
                .serial_clock         (serial_clock),
                .reset                (reset),
                .cfg_default          (gpio_defaults[gi*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
                .cfg_commit           (commit),
                .cfg_new              (sr_reg[gi*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
                .mgmt_gpio_out        (mgmt_gpio_out[gi]),
                .mgmt_gpio_oeb        (mgmt_gpio_oeb[gi]),
                .user_gpio_out        (user_gpio_out[gi]),
                .user_gpio_oeb        (user_gpio_oeb[gi]),
                .pad_gpio_in          (pad_gpio_in[gi]),
                .cfg                  (active_cfg[gi*PAD_CTRL_BITS +: PAD_CTRL_BITS]),
                .mgmt_gpio_in         (mgmt_gpio_in[gi]),
                .user_gpio_in         (user_gpio_in[gi]),
                .pad_gpio_out         (pad_gpio_out[gi]),
                .pad_gpio_outen       (pad_gpio_outen[gi]),
                .pad_gpio_inen        (pad_gpio_inen[gi]),
                .pad_gpio_slew_sel    (pad_gpio_slew_sel[gi]),
                .pad_gpio_schmitt_sel (pad_gpio_schmitt_sel[gi]),
                .pad_gpio_pullup_sel  (pad_gpio_pullup_sel[gi]),
                .pad_gpio_pulldown_sel(pad_gpio_pulldown_sel[gi]),
                .pad_gpio_drive_sel   (pad_gpio_drive_sel[2*gi +: 2])
            );
        end
    endgenerate

endmodule

// File: tb/tb_gpio_control_bank.sv
// Directed self-checking bench for gpio_control_bank (NCH=4, PAD_CTRL_BITS=10).
module tb_gpio_control_bank;

    localparam logic [39:0] DEFAULTS = 40'h00_0000_0403;
    localparam logic [39:0] CFG_A    = {10'h2A4, 10'h10A, 10'h3F6, 10'h00D};
    localparam logic [39:0] CFG_B    = {10'h023, 10'h050, 10'h084, 10'h100};

    logic        serial_clock = 1'b0;
    logic        reset;
    logic [39:0] gpio_defaults;
    logic        serial_data_in, serial_shift_en, serial_load, serial_readback;
    logic        serial_data_out, load_done, load_error;
    logic [3:0]  mgmt_gpio_out, mgmt_gpio_oeb, user_gpio_out, user_gpio_oeb, pad_gpio_in;
    logic [3:0]  mgmt_gpio_in, user_gpio_in, pad_gpio_out, pad_gpio_outen, pad_gpio_inen;
    logic [3:0]  pad_gpio_slew_sel, pad_gpio_schmitt_sel, pad_gpio_pullup_sel, pad_gpio_pulldown_sel;
    logic [7:0]  pad_gpio_drive_sel;

    int n_cmp = 0;
    int n_bad = 0;

    gpio_control_bank #(.NCH(4), .PAD_CTRL_BITS(10)) dut (
        .serial_clock         (serial_clock),
        .reset                (reset),
        .gpio_defaults        (gpio_defaults),
        .serial_data_in       (serial_data_in),
        .serial_shift_en      (serial_shift_en),
        .serial_load          (serial_load),
        .serial_readback      (serial_readback),
        .serial_data_out      (serial_data_out),
        .load_done            (load_done),
        .load_error           (load_error),
        .mgmt_gpio_out        (mgmt_gpio_out),
        .mgmt_gpio_oeb        (mgmt_gpio_oeb),
        .user_gpio_out        (user_gpio_out),
        .user_gpio_oeb        (user_gpio_oeb),
        .pad_gpio_in          (pad_gpio_in),
        .mgmt_gpio_in         (mgmt_gpio_in),
        .user_gpio_in         (user_gpio_in),
        .pad_gpio_out         (pad_gpio_out),
        .pad_gpio_outen       (pad_gpio_outen),
        .pad_gpio_inen        (pad_gpio_inen),
        .pad_gpio_slew_sel    (pad_gpio_slew_sel),
        .pad_gpio_schmitt_sel (pad_gpio_schmitt_sel),
        .pad_gpio_pullup_sel  (pad_gpio_pullup_sel),
        .pad_gpio_pulldown_sel(pad_gpio_pulldown_sel),
        .pad_gpio_drive_sel   (pad_gpio_drive_sel)
    );

    always #5 serial_clock = ~serial_clock;

    task automatic tick();
        @(posedge serial_clock);
        #1;
    endtask

    task automatic shift_bits(input logic [39:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            serial_shift_en = 1'b1;
            serial_data_in  = v[i];
            tick();
        end
        serial_shift_en = 1'b0;
        serial_data_in  = 1'b0;
    endtask

    task automatic test_reset();
        reset           = 1'b1;
        gpio_defaults   = DEFAULTS;
        serial_data_in  = 1'b0;
        serial_shift_en = 1'b0;
        serial_load     = 1'b0;
        serial_readback = 1'b0;
        mgmt_gpio_out   = 4'b1010;
        mgmt_gpio_oeb   = 4'b0011;
        user_gpio_out   = 4'b0101;
        user_gpio_oeb   = 4'b1100;
        pad_gpio_in     = 4'b0110;
        tick();
        tick();
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL reset_load_done got=%b want=0", load_done); end
        n_cmp++; if (serial_data_out !== 1'b0) begin n_bad++; $display("FAIL reset_sdo got=%b want=0", serial_data_out); end
        reset = 1'b0;
        tick();
        n_cmp++; if (load_error !== 1'b0) begin n_bad++; $display("FAIL reset_load_error got=%b want=0", load_error); end
        n_cmp++; if (pad_gpio_out !== 4'b0110) begin n_bad++; $display("FAIL reset_pad_out got=%b want=0110", pad_gpio_out); end
        n_cmp++; if (pad_gpio_outen !== 4'b0000) begin n_bad++; $display("FAIL reset_outen got=%b want=0000", pad_gpio_outen); end
        n_cmp++; if (pad_gpio_inen !== 4'b0000) begin n_bad++; $display("FAIL reset_inen got=%b want=0000", pad_gpio_inen); end
        n_cmp++; if (pad_gpio_drive_sel !== 8'h00) begin n_bad++; $display("FAIL reset_drive got=%h want=00", pad_gpio_drive_sel); end
        n_cmp++; if (mgmt_gpio_in !== 4'b0110 || user_gpio_in !== 4'b0110) begin
            n_bad++; $display("FAIL reset_gpio_in got mgmt=%b user=%b want=0110", mgmt_gpio_in, user_gpio_in);
        end
        $display("test_reset done: pad_out=%b outen=%b", pad_gpio_out, pad_gpio_outen);
    endtask

    task automatic test_load_valid();
        shift_bits(CFG_A, 40);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL valid_done_pulse got=%b want=1", load_done); end
        n_cmp++; if (load_error !== 1'b0) begin n_bad++; $display("FAIL valid_error got=%b want=0", load_error); end
        n_cmp++; if (pad_gpio_inen !== 4'b1011) begin n_bad++; $display("FAIL valid_inen got=%b want=1011", pad_gpio_inen); end
        n_cmp++; if (pad_gpio_schmitt_sel !== 4'b0010) begin n_bad++; $display("FAIL valid_schmitt got=%b want=0010", pad_gpio_schmitt_sel); end
        n_cmp++; if (pad_gpio_slew_sel !== 4'b1010) begin n_bad++; $display("FAIL valid_slew got=%b want=1010", pad_gpio_slew_sel); end
        n_cmp++; if (pad_gpio_pulldown_sel !== 4'b0010) begin n_bad++; $display("FAIL valid_pd got=%b want=0010", pad_gpio_pulldown_sel); end
        n_cmp++; if (pad_gpio_pullup_sel !== 4'b1010) begin n_bad++; $display("FAIL valid_pu got=%b want=1010", pad_gpio_pullup_sel); end
        n_cmp++; if (pad_gpio_drive_sel !== 8'h9C) begin n_bad++; $display("FAIL valid_drive got=%h want=9c", pad_gpio_drive_sel); end
        n_cmp++; if (pad_gpio_outen !== 4'b0100) begin n_bad++; $display("FAIL valid_outen got=%b want=0100", pad_gpio_outen); end
        n_cmp++; if (pad_gpio_out !== 4'b0100) begin n_bad++; $display("FAIL valid_out got=%b want=0100", pad_gpio_out); end
        tick();
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL valid_done_clear got=%b want=0", load_done); end
        mgmt_gpio_out = 4'b1011;
        #1;
        n_cmp++; if (pad_gpio_out !== 4'b0101) begin n_bad++; $display("FAIL valid_out_follow got=%b want=0101", pad_gpio_out); end
        $display("test_load_valid done: inen=%b drive=%h", pad_gpio_inen, pad_gpio_drive_sel);
    endtask

    task automatic test_bad_length();
        shift_bits(CFG_B, 39);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        n_cmp++; if (load_error !== 1'b1) begin n_bad++; $display("FAIL short_error got=%b want=1", load_error); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL short_done got=%b want=0", load_done); end
        n_cmp++; if (pad_gpio_inen !== 4'b1011 || pad_gpio_drive_sel !== 8'h9C) begin
            n_bad++; $display("FAIL short_cfg_kept got inen=%b drive=%h want 1011/9c", pad_gpio_inen, pad_gpio_drive_sel);
        end
        tick();
        n_cmp++; if (load_error !== 1'b1) begin n_bad++; $display("FAIL short_error_sticky got=%b want=1", load_error); end
        shift_bits(CFG_B, 40);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        n_cmp++; if (load_done !== 1'b1) begin n_bad++; $display("FAIL fix_done got=%b want=1", load_done); end
        n_cmp++; if (load_error !== 1'b0) begin n_bad++; $display("FAIL fix_error got=%b want=0", load_error); end
        n_cmp++; if (pad_gpio_inen !== 4'b0010) begin n_bad++; $display("FAIL fix_inen got=%b want=0010", pad_gpio_inen); end
        n_cmp++; if (pad_gpio_pullup_sel !== 4'b0010 || pad_gpio_pulldown_sel !== 4'b0100) begin
            n_bad++; $display("FAIL fix_pull got pu=%b pd=%b want 0010/0100", pad_gpio_pullup_sel, pad_gpio_pulldown_sel);
        end
        n_cmp++; if (pad_gpio_schmitt_sel !== 4'b0100 || pad_gpio_slew_sel !== 4'b1000) begin
            n_bad++; $display("FAIL fix_schmitt_slew got=%b/%b want 0100/1000", pad_gpio_schmitt_sel, pad_gpio_slew_sel);
        end
        n_cmp++; if (pad_gpio_drive_sel !== 8'h01) begin n_bad++; $display("FAIL fix_drive got=%h want=01", pad_gpio_drive_sel); end
        n_cmp++; if (pad_gpio_outen !== 4'b0011) begin n_bad++; $display("FAIL fix_outen got=%b want=0011", pad_gpio_outen); end
        n_cmp++; if (pad_gpio_out !== 4'b1101) begin n_bad++; $display("FAIL fix_out got=%b want=1101", pad_gpio_out); end
        tick();
        $display("test_bad_length done: error=%b inen=%b", load_error, pad_gpio_inen);
    endtask

    task automatic test_readback();
        logic [39:0] exp_cfg;
        exp_cfg = CFG_B;
        shift_bits(40'h7F, 7);
        serial_readback = 1'b1;
        tick();
        serial_readback = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            serial_shift_en = 1'b1;
            serial_data_in  = 1'b0;
            tick();
            n_cmp++;
            if (serial_data_out !== exp_cfg[40-k]) begin
                n_bad++; $display("FAIL readback_bit%0d got=%b want=%b", 40 - k, serial_data_out, exp_cfg[40-k]);
            end
        end
        serial_shift_en = 1'b0;
        $display("test_readback done: 40 bits streamed");
    endtask

    task automatic test_load_held();
        int pulses;
        pulses = 0;
        shift_bits(CFG_A, 40);
        serial_load     = 1'b1;
        serial_readback = 1'b1;
        serial_shift_en = 1'b1;
        serial_data_in  = 1'b1;
        tick();
        if (load_done === 1'b1) pulses++;
        serial_readback = 1'b0;
        serial_shift_en = 1'b0;
        serial_data_in  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (load_done === 1'b1) pulses++;
        end
        serial_load = 1'b0;
        tick();
        if (load_done === 1'b1) pulses++;
        n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL held_pulses got=%0d want=1", pulses); end
        n_cmp++; if (load_error !== 1'b0) begin n_bad++; $display("FAIL held_error got=%b want=0", load_error); end
        n_cmp++; if (pad_gpio_inen !== 4'b1011 || pad_gpio_drive_sel !== 8'h9C) begin
            n_bad++; $display("FAIL held_cfg got inen=%b drive=%h want 1011/9c", pad_gpio_inen, pad_gpio_drive_sel);
        end
        $display("test_load_held done: pulses=%0d", pulses);
    endtask

    task automatic test_saturate();
        shift_bits(40'h1F, 5);
        shift_bits(CFG_B, 40);
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        n_cmp++; if (load_done !== 1'b1 || load_error !== 1'b0) begin
            n_bad++; $display("FAIL sat_load got done=%b err=%b want 1/0", load_done, load_error);
        end
        n_cmp++; if (pad_gpio_inen !== 4'b0010 || pad_gpio_drive_sel !== 8'h01) begin
            n_bad++; $display("FAIL sat_cfg got inen=%b drive=%h want 0010/01", pad_gpio_inen, pad_gpio_drive_sel);
        end
        tick();
        $display("test_saturate done: 45 bits shifted");
    endtask

    task automatic test_reset_mid_shift();
        shift_bits(CFG_A, 20);
        reset = 1'b1;
        #1;
        n_cmp++; if (pad_gpio_inen !== 4'b0000 || pad_gpio_drive_sel !== 8'h00) begin
            n_bad++; $display("FAIL midrst_async_cfg got inen=%b drive=%h want 0000/00", pad_gpio_inen, pad_gpio_drive_sel);
        end
        tick();
        tick();
        reset = 1'b0;
        tick();
        n_cmp++; if (load_error !== 1'b0) begin n_bad++; $display("FAIL midrst_error_clear got=%b want=0", load_error); end
        serial_load = 1'b1;
        tick();
        serial_load = 1'b0;
        n_cmp++; if (load_error !== 1'b1) begin n_bad++; $display("FAIL midrst_error got=%b want=1", load_error); end
        n_cmp++; if (load_done !== 1'b0) begin n_bad++; $display("FAIL midrst_done got=%b want=0", load_done); end
        n_cmp++; if (pad_gpio_out !== 4'b0111 || pad_gpio_outen !== 4'b0000) begin
            n_bad++; $display("FAIL midrst_pads got out=%b outen=%b want 0111/0000", pad_gpio_out, pad_gpio_outen);
        end
        tick();
        $display("test_reset_mid_shift done: error=%b", load_error);
    endtask

    initial begin
        test_reset();
        test_load_valid();
        test_bad_length();
        test_readback();
        test_load_held();
        test_saturate();
        test_reset_mid_shift();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1);
    end

endmodule
